// File: rtl/ram_4k_if.sv
// Memory bus for ram_4k: write data, write enable, word address and read data.
interface ram_4k_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] in;
  logic              load;
  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] out;

  modport master (output in, output load, output sel, input out);
  modport slave  (input in, input load, input sel, output out);
endinterface

// File: rtl/ram_4k.sv
// 4096 x 16 RAM: synchronous write, combinational read, built as
// 8 banks x 8 sub-banks x 8 groups x 8 words with hierarchical decode.
module ram_4k #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic     clk,
  input  logic     reset,
  ram_4k_if.slave  bus
);

  logic [2:0] bank_idx, sub_idx, grp_idx, word_idx;

  assign bank_idx = bus.sel[11:9];
  assign sub_idx  = bus.sel[8:6];
  assign grp_idx  = bus.sel[5:3];
  assign word_idx = bus.sel[2:0];

  logic [7:0]        bank_ld;
  logic [7:0]        sub_ld  [8];
  logic [DATA_W-1:0] grp_rd  [8][8][8];
  logic [DATA_W-1:0] sub_rd  [8][8];
  logic [DATA_W-1:0] bank_rd [8];

  for (genvar b = 0; b < 8; b++) begin : g_bank
    assign bank_ld[b] = bus.load && (bank_idx == 3'(b));

    for (genvar s = 0; s < 8; s++) begin : g_sub
      logic [7:0] grp_ld;

      assign sub_ld[b][s] = bank_ld[b] && (sub_idx == 3'(s));

      for (genvar g = 0; g < 8; g++) begin : g_grp
        logic [DATA_W-1:0] word_q [8];
        logic [7:0]        word_ld;

        assign grp_ld[g] = sub_ld[b][s] && (grp_idx == 3'(g));

        // Leaf decode: only the addressed register sees load.
        for (genvar w = 0; w < 8; w++) begin : g_word
          assign word_ld[w] = grp_ld[g] && (word_idx == 3'(w));

          always_ff @(posedge clk) begin
            if (reset)
              word_q[w] <= '0;
            else if (word_ld[w])
              word_q[w] <= bus.in;
          end
        end

        assign grp_rd[b][s][g] = word_q[word_idx];
      end

      assign sub_rd[b][s] = grp_rd[b][s][grp_idx];
    end

    assign bank_rd[b] = sub_rd[b][sub_idx];
  end

  assign bus.out = bank_rd[bank_idx];

endmodule

// File: tb/tb_ram_4k.sv
// Directed bench for ram_4k: stimulus queues expected read data, a monitor
// process pops and compares against the live read port.
module tb_ram_4k;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  logic clk;
  logic reset;

  ram_4k_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_4k #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] exp_q  [$];
  string             name_q [$];
  event              chk_ev;
  int                checks = 0;
  int                errors = 0;

  // Monitor: drains every queued expectation against the current read data.
  initial begin
    logic [DATA_W-1:0] e;
    string             n;
    forever begin
      @(chk_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.out !== e) begin
          errors++;
          $display("FAIL %s: sel=%03h out=%04h expected=%04h", n, bus.sel, bus.out, e);
        end
      end
    end
  end

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [DATA_W-1:0] v);
    #1;
    exp_q.push_back(v);
    name_q.push_back(n);
    -> chk_ev;
    #1;
  endtask

  task automatic read_at(input string n, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] v);
    bus.sel = a;
    expect_out(n, v);
  endtask

  task automatic write_at(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.sel  = a;
    bus.in   = d;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    bus.in   = '0;
    bus.load = 1'b0;
    bus.sel  = '0;
    #10;

    // Reset clears the array.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_at("rst_000", 12'h000, 16'h0000);
    read_at("rst_958", 12'h958, 16'h0000);
    read_at("rst_fff", 12'hFFF, 16'h0000);

    // load=0 must not write; load=1 must.
    bus.in = 16'hF00D; bus.sel = 12'h958; bus.load = 1'b0;
    tick();
    expect_out("noload_958", 16'h0000);
    write_at(12'h958, 16'hF00D);
    expect_out("raw_958", 16'hF00D);

    write_at(12'h02B, 16'hDEAF);
    expect_out("raw_02b", 16'hDEAF);
    read_at("keep_958", 12'h958, 16'hF00D);

    // Extremes of the address range and their neighbours.
    write_at(12'h000, 16'h1234);
    write_at(12'hFFF, 16'hABCD);
    read_at("wr_000", 12'h000, 16'h1234);
    read_at("wr_fff", 12'hFFF, 16'hABCD);
    read_at("nbr_001", 12'h001, 16'h0000);
    read_at("nbr_ffe", 12'hFFE, 16'h0000);

    // Same offset in another bank must be a separate word.
    write_at(12'h158, 16'h5555);
    read_at("bank_158", 12'h158, 16'h5555);
    read_at("bank_958", 12'h958, 16'hF00D);
    read_at("sub_918", 12'h918, 16'h0000);
    read_at("grp_950", 12'h950, 16'h0000);

    // Reset wins over a simultaneous write.
    reset = 1'b1; bus.load = 1'b1; bus.in = 16'hFFFF; bus.sel = 12'h958;
    tick();
    reset = 1'b0; bus.load = 1'b0;
    read_at("rl_958", 12'h958, 16'h0000);
    read_at("rl_02b", 12'h02B, 16'h0000);
    read_at("rl_000", 12'h000, 16'h0000);
    read_at("rl_fff", 12'hFFF, 16'h0000);
    read_at("rl_158", 12'h158, 16'h0000);

    // Writes resume after reset; toggling inputs with clk low changes nothing.
    write_at(12'h3C3, 16'h0BAD);
    bus.load = 1'b1; bus.in = 16'hFFFF; bus.sel = 12'h3C3;
    expect_out("low_3c3_a", 16'h0BAD);
    bus.sel = 12'h3C4; bus.in = 16'h1111;
    expect_out("low_3c4", 16'h0000);
    bus.sel = 12'h3C3; bus.in = 16'h2222;
    expect_out("low_3c3_b", 16'h0BAD);
    bus.load = 1'b0;
    expect_out("low_3c3_c", 16'h0BAD);

    // Old value before the edge, new value right after it.
    bus.load = 1'b1; bus.in = 16'h2222;
    expect_out("pre_edge", 16'h0BAD);
    tick();
    bus.load = 1'b0;
    expect_out("post_edge", 16'h2222);
    read_at("post_3c4", 12'h3C4, 16'h0000);

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
